register_file_mp: RTL and testbench
===================================

// Module: register_file_mp
// PURPOSE
//  Parametrised multi-port integer register file; next generation of the core register file.
//  N combinational read ports and two write ports (ALU and load writeback), with
//  optional write-to-read bypass and a per-register busy scoreboard for hazard detection.
//  Sits in the decode stage; writeback stages drive the write ports.
// PARAMETERS
//  DATA_WIDTH      32  width of each register
//  ADDR_WIDTH      5   register index width; depth = 2**ADDR_WIDTH
//  NUM_READ_PORTS  2   number of read ports (1..4)
//  BYPASS          1   1: a same-cycle write is forwarded to matching reads; 0: no forwarding
// PORTS
//  CLK             in   1                      clock; all state updates on posedge
//  RST             in   1                      synchronous reset, active-high
//  WRITE_ENABLE_0  in   1                      write port 0 enable (ALU writeback)
//  WRITE_REG_0     in   ADDR_WIDTH             write port 0 index
//  WRITE_DATA_0    in   DATA_WIDTH             write port 0 data
//  WRITE_ENABLE_1  in   1                      write port 1 enable (load writeback)
//  WRITE_REG_1     in   ADDR_WIDTH             write port 1 index
//  WRITE_DATA_1    in   DATA_WIDTH             write port 1 data
//  READ_REG        in   NUM_READ_PORTS*ADDR_WIDTH  packed read indices; port k = [k*AW +: AW]
//  READ_DATA       out  NUM_READ_PORTS*DATA_WIDTH  packed read data, same packing
//  READ_BUSY       out  NUM_READ_PORTS         1 = addressed register has an outstanding producer
//  BUSY_SET        in   1                      mark BUSY_SET_REG busy (instruction issue)
//  BUSY_SET_REG    in   ADDR_WIDTH             register to mark busy
// BEHAVIOUR
//  - Reset: when RST=1 at posedge, all registers <= 0 and all busy bits <= 0; writes and
//    BUSY_SET in that cycle are ignored. After reset, every READ_DATA = 0 and READ_BUSY = 0.
//  - Register 0: always reads 0 and is never busy; writes and BUSY_SET to index 0 are dropped.
//  - Write: on posedge with WRITE_ENABLE_p=1, RST=0 and index!=0, reg <= WRITE_DATA_p.
//  - Same-index dual write: port 1 wins; port 0 data is discarded.
//  - Read: combinational from array; zero latency.
//  - Bypass (BYPASS=1, RST=0): if a write port is enabled to a nonzero index equal to a read
//    index, READ_DATA returns that write data in the same cycle (port 1 beats port 0).
//    BYPASS=0: reads return the stored value; new data is visible the cycle after the edge.
//  - Scoreboard: busy[i] set at posedge when BUSY_SET=1 and BUSY_SET_REG=i!=0; cleared at
//    posedge when either write port commits to i.
//  - Simultaneous set and clear of the same index: set wins (newer producer outstanding).
//  - READ_BUSY[k] = busy[READ_REG_k]; with BYPASS=1, forced to 0 when a write to that index
//    is being forwarded in the cycle and BUSY_SET does not target it.
//  - A write to a non-busy register is legal; it updates data and leaves busy at 0.
//  - Reset mid-operation: pending busy bits are lost and in-flight writes in the RST cycle
//    are dropped; the pipeline is flushed by the same reset.
// STRUCTURE
//  - Shared package rf_pkg: ZERO_REG index constant, default DATA_WIDTH/ADDR_WIDTH, and
//    port-slice helper macros for packed read buses.
//  - Sub-module register_scoreboard (ADDR_WIDTH): busy vector, set/clear logic, and
//    NUM_READ_PORTS lookups; the data array, write arbitration and bypass muxes stay in top.
//  - Read ports generated with a generate-for over NUM_READ_PORTS.
// TESTING
//  1. Assert RST for 1 cycle after writing 0x1234 to x5 -> x5 reads 0; all READ_BUSY = 0.
//  2. Write 0xAAAA_AAAA to x1 via port 0, and in the same cycle 0x5555_5555 to x1 via port 1
//     -> x1 reads 0x5555_5555 next cycle.
//  3. Write 0xFFFF_FFFF to x0 and issue BUSY_SET on x0 -> READ_DATA = 0 and READ_BUSY = 0.
//  4. BYPASS=1: read x2 while writing 0xDEAD_BEEF to x2 -> READ_DATA = 0xDEAD_BEEF in the
//     same cycle. BYPASS=0: old value this cycle, 0xDEAD_BEEF the next cycle.
//  5. BUSY_SET x7 -> READ_BUSY = 1. Then write x7 via port 1 -> READ_BUSY = 0.
//     Then BUSY_SET x7 together with a port 0 write to x7 -> READ_BUSY stays 1.
//  6. NUM_READ_PORTS=3: fill x1..x31 with value i*0x0101_0101, sweep all 3 ports over
//     every index -> all match; x0 = 0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file: default geometry, the hardwired
// zero register index, and a slice helper for packed per-port buses.
`ifndef RF_PKG_SV
`define RF_PKG_SV

// Part-select for port k of a packed bus with per-port width w.
`define RF_SLICE(k, w) ((k) * (w)) +: (w)

package rf_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 5;
    localparam int unsigned DEF_READ_PORTS = 2;
    localparam int unsigned ZERO_REG       = 0;

endpackage

`endif

// File: rtl/register_scoreboard.sv
// Per-register busy tracking: set on issue, cleared on writeback, looked up by each read port.
module register_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned NUM_READ_PORTS = DEF_READ_PORTS
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               busy_set,
    input  logic [ADDR_WIDTH-1:0]              busy_set_reg,
    input  logic                               clear_0,
    input  logic [ADDR_WIDTH-1:0]              clear_reg_0,
    input  logic                               clear_1,
    input  logic [ADDR_WIDTH-1:0]              clear_reg_1,
    input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] lookup_reg,
    output logic [NUM_READ_PORTS-1:0]          lookup_busy
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_next;

    // Set is applied after clears so a newly issued producer stays outstanding.
    always_comb begin
        busy_next = busy;
        if (clear_0) begin
            busy_next[clear_reg_0] = 1'b0;
        end
        if (clear_1) begin
            busy_next[clear_reg_1] = 1'b0;
        end
        if (busy_set) begin
            busy_next[busy_set_reg] = 1'b1;
        end
        busy_next[ZERO_IDX] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    for (genvar k = 0; k < NUM_READ_PORTS; k++) begin : g_lookup
        logic [ADDR_WIDTH-1:0] idx;
        assign idx            = lookup_reg[`RF_SLICE(k, ADDR_WIDTH)];
        assign lookup_busy[k] = busy[idx];
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port integer register file with two writeback ports, optional same-cycle
// write-to-read forwarding, and a busy scoreboard for hazard detection in decode.
module register_file_mp
    import rf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned NUM_READ_PORTS = DEF_READ_PORTS,
    parameter int unsigned BYPASS         = 1
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic                                 WRITE_ENABLE_0,
    input  logic [ADDR_WIDTH-1:0]                WRITE_REG_0,
    input  logic [DATA_WIDTH-1:0]                WRITE_DATA_0,
    input  logic                                 WRITE_ENABLE_1,
    input  logic [ADDR_WIDTH-1:0]                WRITE_REG_1,
    input  logic [DATA_WIDTH-1:0]                WRITE_DATA_1,
    input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] READ_REG,
    output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] READ_DATA,
    output logic [NUM_READ_PORTS-1:0]            READ_BUSY,
    input  logic                                 BUSY_SET,
    input  logic [ADDR_WIDTH-1:0]                BUSY_SET_REG
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);
    localparam logic FORWARD = (BYPASS != 0);

    logic [DATA_WIDTH-1:0]     regs [DEPTH];
    logic                      commit_0;
    logic                      commit_1;
    logic                      busy_set_ok;
    logic [NUM_READ_PORTS-1:0] raw_busy;

    // Writes to the zero register and writes in a reset cycle never commit.
    assign commit_0    = !RST && WRITE_ENABLE_0 && (WRITE_REG_0 != ZERO_IDX);
    assign commit_1    = !RST && WRITE_ENABLE_1 && (WRITE_REG_1 != ZERO_IDX);
    assign busy_set_ok = BUSY_SET && (BUSY_SET_REG != ZERO_IDX);

    // Port 1 is assigned last so it wins a same-index collision.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (commit_0) begin
                regs[WRITE_REG_0] <= WRITE_DATA_0;
            end
            if (commit_1) begin
                regs[WRITE_REG_1] <= WRITE_DATA_1;
            end
        end
    end

    register_scoreboard #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .NUM_READ_PORTS (NUM_READ_PORTS)
    ) u_scoreboard (
        .CLK          (CLK),
        .RST          (RST),
        .busy_set     (busy_set_ok),
        .busy_set_reg (BUSY_SET_REG),
        .clear_0      (commit_0),
        .clear_reg_0  (WRITE_REG_0),
        .clear_1      (commit_1),
        .clear_reg_1  (WRITE_REG_1),
        .lookup_reg   (READ_REG),
        .lookup_busy  (raw_busy)
    );

    for (genvar k = 0; k < NUM_READ_PORTS; k++) begin : g_read
        logic [ADDR_WIDTH-1:0] idx;
        logic                  hit_0;
        logic                  hit_1;
        logic                  set_hit;
        logic [DATA_WIDTH-1:0] rd_data;
        logic                  rd_busy;

        assign idx     = READ_REG[`RF_SLICE(k, ADDR_WIDTH)];
        assign hit_0   = FORWARD && commit_0 && (WRITE_REG_0 == idx);
        assign hit_1   = FORWARD && commit_1 && (WRITE_REG_1 == idx);
        assign set_hit = busy_set_ok && (BUSY_SET_REG == idx);

        always_comb begin
            rd_data = regs[idx];
            if (idx == ZERO_IDX) begin
                rd_data = '0;
            end else if (hit_1) begin
                rd_data = WRITE_DATA_1;
            end else if (hit_0) begin
                rd_data = WRITE_DATA_0;
            end
        end

        // A forwarded write resolves the hazard unless a new producer issues this cycle.
        always_comb begin
            rd_busy = raw_busy[k];
            if ((hit_0 || hit_1) && !set_hit) begin
                rd_busy = 1'b0;
            end
        end

        assign READ_DATA[`RF_SLICE(k, DATA_WIDTH)] = rd_data;
        assign READ_BUSY[k]                        = rd_busy;
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench: one forwarding and one non-forwarding register file share stimulus;
// expectations from an array model are queued and checked by a separate monitor.
`timescale 1ns/1ps
module tb_register_file_mp;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NRP = 3;
    localparam int NREG = 32;

    logic              CLK;
    logic              RST;
    logic              we0, we1, bset;
    logic [AW-1:0]     wr0, wr1, bsreg;
    logic [DW-1:0]     wd0, wd1;
    logic [NRP*AW-1:0] rreg;
    logic [NRP*DW-1:0] rd_b, rd_n;
    logic [NRP-1:0]    rbusy_b, rbusy_n;

    typedef struct {
        int          dut;
        int          port;
        int          reg_idx;
        logic [31:0] data;
        logic        busy;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mreg [NREG];
    bit          mbusy [NREG];

    register_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ_PORTS(NRP), .BYPASS(1)) dut_b (
        .CLK(CLK), .RST(RST),
        .WRITE_ENABLE_0(we0), .WRITE_REG_0(wr0), .WRITE_DATA_0(wd0),
        .WRITE_ENABLE_1(we1), .WRITE_REG_1(wr1), .WRITE_DATA_1(wd1),
        .READ_REG(rreg), .READ_DATA(rd_b), .READ_BUSY(rbusy_b),
        .BUSY_SET(bset), .BUSY_SET_REG(bsreg)
    );

    register_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ_PORTS(NRP), .BYPASS(0)) dut_n (
        .CLK(CLK), .RST(RST),
        .WRITE_ENABLE_0(we0), .WRITE_REG_0(wr0), .WRITE_DATA_0(wd0),
        .WRITE_ENABLE_1(we1), .WRITE_REG_1(wr1), .WRITE_DATA_1(wd1),
        .READ_REG(rreg), .READ_DATA(rd_n), .READ_BUSY(rbusy_n),
        .BUSY_SET(bset), .BUSY_SET_REG(bsreg)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Reference: what a read of register r returns this cycle, given the current inputs.
    task automatic expect_read(input int r, input bit byp, output logic [31:0] d, output logic b);
        bit fwd;
        d   = mreg[r];
        b   = mbusy[r];
        fwd = 1'b0;
        if (r == 0) begin
            d = 32'h0;
            b = 1'b0;
        end else if (byp && !RST) begin
            if (we1 && int'(wr1) == r) begin
                d   = wd1;
                fwd = 1'b1;
            end else if (we0 && int'(wr0) == r) begin
                d   = wd0;
                fwd = 1'b1;
            end
            if (fwd && !(bset && int'(bsreg) == r)) b = 1'b0;
        end
    endtask

    // Architectural effect of one clock edge on the model.
    task automatic model_edge();
        if (RST) begin
            for (int i = 0; i < NREG; i++) begin
                mreg[i]  = 32'h0;
                mbusy[i] = 1'b0;
            end
        end else begin
            if (we0 && wr0 != 0) begin mreg[wr0] = wd0; mbusy[wr0] = 1'b0; end
            if (we1 && wr1 != 0) begin mreg[wr1] = wd1; mbusy[wr1] = 1'b0; end
            if (bset && bsreg != 0) mbusy[bsreg] = 1'b1;
        end
    endtask

    task automatic step();
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < NRP; k++) begin
                e.dut     = d;
                e.port    = k;
                e.reg_idx = int'(rreg[k*AW +: AW]);
                expect_read(e.reg_idx, (d == 0), e.data, e.busy);
                exp_q.push_back(e);
            end
        end
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic idle();
        RST = 1'b0;
        we0 = 1'b0; wr0 = '0; wd0 = '0;
        we1 = 1'b0; wr1 = '0; wd1 = '0;
        bset = 1'b0; bsreg = '0;
    endtask

    task automatic set_reads(input int r0, input int r1, input int r2);
        rreg[0*AW +: AW] = AW'(r0);
        rreg[1*AW +: AW] = AW'(r1);
        rreg[2*AW +: AW] = AW'(r2);
    endtask

    // Monitor: outputs are combinational, so each cycle's expectations are checked mid-cycle.
    initial begin
        exp_t        e;
        logic [31:0] act_d;
        logic        act_b;
        forever begin
            @(negedge CLK);
            while (exp_q.size() > 0) begin
                e     = exp_q.pop_front();
                act_d = (e.dut == 0) ? rd_b[e.port*DW +: DW] : rd_n[e.port*DW +: DW];
                act_b = (e.dut == 0) ? rbusy_b[e.port] : rbusy_n[e.port];
                checks++;
                if (act_d !== e.data) begin
                    errors++;
                    $display("FAIL read_data byp=%0d port%0d x%0d @%0t: got %h expected %h",
                             (e.dut == 0), e.port, e.reg_idx, $time, act_d, e.data);
                end
                checks++;
                if (act_b !== e.busy) begin
                    errors++;
                    $display("FAIL read_busy byp=%0d port%0d x%0d @%0t: got %b expected %b",
                             (e.dut == 0), e.port, e.reg_idx, $time, act_b, e.busy);
                end
            end
        end
    end

    initial begin
        idle();
        RST  = 1'b1;
        rreg = '0;
        @(posedge CLK);
        model_edge();
        #1;
        RST = 1'b1; set_reads(0, 1, 2); step();
        idle(); set_reads(5, 1, 31); step();

        // Reset drops a prior write and any pending busy bits.
        we0 = 1'b1; wr0 = 5'd5; wd0 = 32'h0000_1234; bset = 1'b1; bsreg = 5'd9; step();
        idle(); set_reads(5, 9, 0); step();
        RST = 1'b1; step();
        idle(); step();

        // Dual write to the same index: port 1 wins.
        we0 = 1'b1; wr0 = 5'd1; wd0 = 32'hAAAA_AAAA;
        we1 = 1'b1; wr1 = 5'd1; wd1 = 32'h5555_5555;
        set_reads(1, 1, 0); step();
        idle(); step();

        // Register 0 ignores writes and busy marking.
        we0 = 1'b1; wr0 = 5'd0; wd0 = 32'hFFFF_FFFF;
        we1 = 1'b1; wr1 = 5'd0; wd1 = 32'hFFFF_FFFF;
        bset = 1'b1; bsreg = 5'd0; set_reads(0, 0, 0); step();
        idle(); step();

        // Forwarding versus stored value.
        we0 = 1'b1; wr0 = 5'd2; wd0 = 32'h0000_0011; set_reads(2, 3, 2); step();
        idle(); we0 = 1'b1; wr0 = 5'd2; wd0 = 32'hDEAD_BEEF; step();
        idle(); step();

        // Scoreboard set, clear by port 1, then set racing a port 0 clear.
        bset = 1'b1; bsreg = 5'd7; set_reads(7, 7, 6); step();
        idle(); step();
        we1 = 1'b1; wr1 = 5'd7; wd1 = 32'h0000_0777; step();
        idle(); step();
        bset = 1'b1; bsreg = 5'd7; we0 = 1'b1; wr0 = 5'd7; wd0 = 32'h0000_0070; step();
        idle(); step();
        step();

        // Fill x1..x31, then sweep every index across all three ports.
        for (int i = 1; i < NREG; i++) begin
            idle();
            if (i % 2 == 1) begin we0 = 1'b1; wr0 = AW'(i); wd0 = 32'(i) * 32'h0101_0101; end
            else            begin we1 = 1'b1; wr1 = AW'(i); wd1 = 32'(i) * 32'h0101_0101; end
            set_reads(i, (i + 1) % NREG, (i + 2) % NREG);
            step();
        end
        idle();
        for (int i = 0; i < NREG; i++) begin
            set_reads(i, (i + 11) % NREG, (i + 23) % NREG);
            step();
        end

        // Randomised traffic concentrated on a few indices to provoke collisions.
        for (int n = 0; n < 2000; n++) begin
            idle();
            RST   = ($urandom_range(0, 63) == 0);
            we0   = $urandom_range(0, 1);
            we1   = $urandom_range(0, 1);
            bset  = $urandom_range(0, 1);
            wr0   = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            wr1   = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            bsreg = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            wd0   = $urandom;
            wd1   = $urandom;
            set_reads($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, NREG - 1));
            step();
        end

        idle();
        step();
        @(negedge CLK);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
